// File: rtl/oscillator_if.sv
// Control/observe bundle for one oscillator voice.
// The wave signal exists only when OSCILLATOR_WAVE_EN is defined.
interface oscillator_if #(
  parameter int WIDTH = 16
);
  logic             en;
  logic [WIDTH-1:0] divider;
  logic [WIDTH-1:0] count;
`ifdef OSCILLATOR_WAVE_EN
  logic             wave;

  modport master (output en, output divider, input count, input wave);
  modport slave  (input en, input divider, output count, output wave);
`else
  modport master (output en, output divider, input count);
  modport slave  (input en, input divider, output count);
`endif
endinterface

// File: rtl/oscillator.sv
// Programmable period counter: the timebase of one synth voice. count sweeps 1..divider.
// Optional feature macro: OSCILLATOR_WAVE_EN adds a square-wave output that toggles on each wrap.
module oscillator #(
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        nrst,
  oscillator_if.slave osc
);

  logic [WIDTH-1:0] count_q;
  logic             wrap;

  // >= rather than == so that shrinking divider mid-sweep wraps instead of overrunning
  assign wrap = (count_q >= osc.divider);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count_q <= '0;
    end else if (!osc.en) begin
      count_q <= WIDTH'(1);
    end else if (wrap) begin
      count_q <= WIDTH'(1);
    end else begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign osc.count = count_q;

`ifdef OSCILLATOR_WAVE_EN
  logic wave_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wave_q <= 1'b0;
    end else if (!osc.en) begin
      wave_q <= 1'b0;
    end else if (wrap) begin
      wave_q <= ~wave_q;
    end
  end

  assign osc.wave = wave_q;
`endif

endmodule

// File: tb/tb_oscillator.sv
// Self-checking bench for oscillator: directed sweeps plus randomized en/divider/reset
// traffic compared against a sweep-position reference model.
module tb_oscillator;
  localparam int WIDTH = 16;

  logic tb_clk = 1'b0;
  logic nrst;
  int   errors = 0;
  int   checks = 0;

  // reference state: position within the current sweep and square-wave level
  int unsigned m_pos;
  bit          m_wave;

  oscillator_if #(.WIDTH(WIDTH)) osc_bus ();

  oscillator #(.WIDTH(WIDTH)) dut (
    .clk  (tb_clk),
    .nrst (nrst),
    .osc  (osc_bus)
  );

  always #5 tb_clk = ~tb_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int unsigned period_of(input int unsigned div);
    return (div < 2) ? 1 : div;
  endfunction

  // Reference: a sweep visits positions 1..period; a disabled edge parks at 1,
  // and the last position of the sweep (or beyond it) starts a new sweep.
  task automatic tick();
    int unsigned per;
    @(posedge tb_clk);
    per = period_of(int'(osc_bus.divider));
    if (!nrst) begin
      m_pos  = 0;
      m_wave = 1'b0;
    end else if (!osc_bus.en) begin
      m_pos  = 1;
      m_wave = 1'b0;
    end else if (m_pos != 0 && m_pos >= per) begin
      m_pos  = 1;
      m_wave = ~m_wave;
    end else begin
      m_pos  = (m_pos == 0) ? 1 : m_pos + 1;
    end
    #1;
    chk("count", 32'(osc_bus.count), m_pos);
`ifdef OSCILLATOR_WAVE_EN
    chk("wave", 32'(osc_bus.wave), 32'(m_wave));
`endif
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_div(input int unsigned d);
    osc_bus.divider = WIDTH'(d);
  endtask

  // Asserts nrst between edges, checks the immediate clear, holds over one edge, releases at negedge.
  task automatic async_reset();
    #2;
    nrst   = 1'b0;
    m_pos  = 0;
    m_wave = 1'b0;
    #1;
    chk("rst_immediate", 32'(osc_bus.count), 32'd0);
`ifdef OSCILLATOR_WAVE_EN
    chk("rst_wave", 32'(osc_bus.wave), 32'd0);
`endif
    tick();
    @(negedge tb_clk);
    nrst = 1'b1;
    #1;
    chk("rst_release", 32'(osc_bus.count), 32'd0);
  endtask

  task automatic start_run(input int unsigned div);
    async_reset();
    osc_bus.en = 1'b0;
    tick();
    tick();
    chk("idle_preload", 32'(osc_bus.count), 32'd1);
    osc_bus.en = 1'b1;
    set_div(div);
  endtask

  initial begin
    nrst           = 1'b0;
    osc_bus.en     = 1'b0;
    osc_bus.divider = WIDTH'(1);
    m_pos          = 0;
    m_wave         = 1'b0;

    // power-on: held in reset across edges, then released at a negedge
    @(posedge tb_clk);
    #1 chk("por_half", 32'(osc_bus.count), 32'd0);
    @(posedge tb_clk);
    #1 chk("por_full", 32'(osc_bus.count), 32'd0);
    @(negedge tb_clk);
    nrst = 1'b1;
    #1 chk("por_release", 32'(osc_bus.count), 32'd0);
    tick();
    tick();
    chk("por_idle", 32'(osc_bus.count), 32'd1);

    // A4 sweep
    start_run(22727);
    tick();
    chk("a4_first", 32'(osc_bus.count), 32'd2);
    run(22725);
    chk("a4_top", 32'(osc_bus.count), 32'd22727);
    tick();
    chk("a4_wrap", 32'(osc_bus.count), 32'd1);

    // arbitrary divider
    start_run(30000);
    tick();
    chk("arb_first", 32'(osc_bus.count), 32'd2);
    run(29998);
    chk("arb_top", 32'(osc_bus.count), 32'd30000);
    tick();
    chk("arb_wrap", 32'(osc_bus.count), 32'd1);

    // live divider decrease below the current position
    set_div(100);
    run(49);
    chk("live_at50", 32'(osc_bus.count), 32'd50);
    set_div(10);
    tick();
    chk("live_wrap", 32'(osc_bus.count), 32'd1);
    for (int k = 2; k <= 10; k++) begin
      tick();
      chk("live_sweep", 32'(osc_bus.count), 32'(k));
    end
    tick();
    chk("live_sweep_wrap", 32'(osc_bus.count), 32'd1);

    // disable mid-sweep
    set_div(100);
    run(36);
    chk("dis_at37", 32'(osc_bus.count), 32'd37);
    osc_bus.en = 1'b0;
    tick();
    chk("dis_idle", 32'(osc_bus.count), 32'd1);
    osc_bus.en = 1'b1;
    tick();
    chk("dis_restart", 32'(osc_bus.count), 32'd2);

    // degenerate dividers
    set_div(0);
    run(4);
    chk("div0_hold", 32'(osc_bus.count), 32'd1);
    set_div(1);
    run(4);
    chk("div1_hold", 32'(osc_bus.count), 32'd1);

    // enabled straight out of reset
    set_div(10);
    run(5);
    async_reset();
    tick();
    chk("rst_en_first", 32'(osc_bus.count), 32'd1);
    tick();
    chk("rst_en_second", 32'(osc_bus.count), 32'd2);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(7) == 0) set_div($urandom_range(0, 24));
      osc_bus.en = ($urandom_range(9) != 0);
      if ($urandom_range(149) == 0) async_reset();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
